// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// The PC_SEQ_PERF_EN build option itself is handled in pc_sequencer.sv.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } pc_state_t;

  localparam int         INC_DEFAULT = 4;
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

  // Only the two low address bits decide word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |(addr_lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// IF-stage control bundle between the hazard/EX logic, the PC sequencer and imem.
// The PC_SEQ_PERF_EN counters are plain ports on pc_sequencer, not part of this bundle.
interface pc_sequencer_if #(
  parameter int XLEN = 32
);
  import pc_seq_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            halt_req;
  logic            resume;
  logic            imem_ready;
  logic [XLEN-1:0] pc;
  logic            fetch_valid;
  logic            flush;
  logic            fault;
  pc_state_t       state;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           halt_req, resume, imem_ready,
    input  pc, fetch_valid, flush, fault, state
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           halt_req, resume, imem_ready,
    output pc, fetch_valid, flush, fault, state
  );

endinterface

// File: rtl/pc_adder.sv
// pcAdder: sequential next-PC increment, wrapping at XLEN bits.
// Not affected by the PC_SEQ_PERF_EN build option.
module pc_adder #(
  parameter int XLEN = 32,
  parameter int INC  = 4
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_o
);

  assign pc_o = pc_i + XLEN'(INC);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot, sequential fetch, redirects, imem wait and halt.
// Define PC_SEQ_PERF_EN to add saturating fetch/redirect/stall counters.
//
//   state  | meaning
//   BOOT   | one cycle after reset, pc held, no fetch
//   RUN    | fetching, pc advances or is redirected
//   WAIT   | imem not ready, pc held until it accepts
//   HALTED | fetch stopped by halt_req or misaligned redirect
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = INC_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   redirect_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc_inc;

  logic            active;
  logic            redir_req;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad;
  logic            go_halt;
  logic            go_redir;
  logic            hold_stall;
  logic            hold_rdy;
  logic            seq_adv;

  pc_adder #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_pc_adder (
    .pc_i (pc_q),
    .pc_o (pc_inc)
  );

  // Event decode shared by the FSM and the optional counters.
  // In WAIT an unready imem keeps us waiting even when stall is also high.
  always_comb begin
    active     = (state_q == ST_RUN) || (state_q == ST_WAIT);
    redir_req  = bus.jump | bus.branch_taken;
    redir_tgt  = bus.jump ? bus.jump_target : bus.branch_target;
    redir_bad  = is_misaligned(redir_tgt[1:0]);
    go_halt    = active & bus.halt_req;
    go_redir   = active & ~bus.halt_req & redir_req;
    hold_stall = active & ~bus.halt_req & ~redir_req & bus.stall &
                 ((state_q == ST_RUN) | bus.imem_ready);
    hold_rdy   = active & ~bus.halt_req & ~redir_req & ~hold_stall & ~bus.imem_ready;
    seq_adv    = active & ~bus.halt_req & ~redir_req & ~hold_stall & bus.imem_ready;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_d = 1'b0;
    fault_d = fault_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN, ST_WAIT: begin
        if (go_halt) begin
          state_d = ST_HALTED;
        end else if (go_redir) begin
          if (redir_bad) begin
            fault_d = 1'b1;
            state_d = ST_HALTED;
          end else begin
            pc_d    = redir_tgt;
            flush_d = 1'b1;
            state_d = ST_RUN;
          end
        end else if (hold_stall) begin
          state_d = ST_RUN;
        end else if (hold_rdy) begin
          state_d = ST_WAIT;
        end else if (seq_adv) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (bus.resume && !fault_q) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.state       = state_q;
  assign bus.fetch_valid = active;
  assign bus.flush       = flush_q;
  assign bus.fault       = fault_q;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (seq_adv && (fetch_cnt_q != '1))
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (go_redir && !redir_bad && (redirect_cnt_q != '1))
      redirect_cnt_d = redirect_cnt_q + 32'd1;
    if ((hold_stall || hold_rdy) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven scoreboard bench for pc_sequencer; builds with or without PC_SEQ_PERF_EN.
module tb_pc_sequencer;

  logic clk;
  logic rst;

  pc_sequencer_if #(.XLEN(32)) bus ();

`ifdef PC_SEQ_PERF_EN
  logic [31:0] fetch_cnt, redirect_cnt, stall_cnt;
`endif

  pc_sequencer #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0000),
    .INC       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef PC_SEQ_PERF_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] jmp_tgt;
    logic        halt;
    logic        resume;
    logic        rdy;
    logic [31:0] e_pc;
    logic [1:0]  e_st;
    logic        e_fv;
    logic        e_fl;
    logic        e_ft;
  } vec_t;

  localparam logic [1:0] B = 2'd0, R = 2'd1, W = 2'd2, H = 2'd3;

  vec_t tbl[$];
  vec_t tbl2[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string nm, logic st, logic br, logic [31:0] bt,
                              logic jp, logic [31:0] jt, logic hl, logic rs,
                              logic rdy, logic [31:0] epc, logic [1:0] est,
                              logic efv, logic efl, logic eft);
    vec_t v;
    v.name = nm; v.stall = st; v.br = br; v.br_tgt = bt; v.jmp = jp; v.jmp_tgt = jt;
    v.halt = hl; v.resume = rs; v.rdy = rdy;
    v.e_pc = epc; v.e_st = est; v.e_fv = efv; v.e_fl = efl; v.e_ft = eft;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] epc, logic [1:0] est,
                       logic efv, logic efl, logic eft);
    total++;
    if (bus.pc !== epc || bus.state !== est || bus.fetch_valid !== efv ||
        bus.flush !== efl || bus.fault !== eft) begin
      bad++;
      $display("FAIL %s: got pc=%h st=%0d fv=%b fl=%b ft=%b want pc=%h st=%0d fv=%b fl=%b ft=%b",
               nm, bus.pc, bus.state, bus.fetch_valid, bus.flush, bus.fault,
               epc, est, efv, efl, eft);
    end
  endtask

  task automatic check_cnt(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.jump = 0; bus.jump_target = '0; bus.halt_req = 0;
    bus.resume = 0; bus.imem_ready = 1;
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    bus.stall = v.stall; bus.branch_taken = v.br; bus.branch_target = v.br_tgt;
    bus.jump = v.jmp; bus.jump_target = v.jmp_tgt; bus.halt_req = v.halt;
    bus.resume = v.resume; bus.imem_ready = v.rdy;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.name, e.e_pc, e.e_st, e.e_fv, e.e_fl, e.e_ft);
  endtask

  initial begin
    //                 name          st br  btgt          jp jtgt          hl rs rdy  e_pc          st fv fl ft
    tbl.push_back(mk("boot_exit",   0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0000, R, 1, 0, 0));
    tbl.push_back(mk("seq_4",       0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0004, R, 1, 0, 0));
    tbl.push_back(mk("seq_8",       0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0008, R, 1, 0, 0));
    tbl.push_back(mk("seq_c",       0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_000C, R, 1, 0, 0));
    tbl.push_back(mk("seq_10",      0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0010, R, 1, 0, 0));
    tbl.push_back(mk("br_over_stl", 1, 1, 32'h40,       0, 32'h0,        0, 0, 1, 32'h0000_0040, R, 1, 1, 0));
    tbl.push_back(mk("stall_a",     1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0040, R, 1, 0, 0));
    tbl.push_back(mk("stall_b",     1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0040, R, 1, 0, 0));
    tbl.push_back(mk("unstall",     0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0044, R, 1, 0, 0));
    tbl.push_back(mk("jmp_beats_br",0, 1, 32'h200,      1, 32'h100,      0, 0, 1, 32'h0000_0100, R, 1, 1, 0));
    tbl.push_back(mk("jmp_top",     0, 0, 32'h0,        1, 32'hFFFF_FFFC,0, 0, 1, 32'hFFFF_FFFC, R, 1, 1, 0));
    tbl.push_back(mk("wrap",        0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0000, R, 1, 0, 0));
    tbl.push_back(mk("jmp_20",      0, 0, 32'h0,        1, 32'h20,       0, 0, 1, 32'h0000_0020, R, 1, 1, 0));
    tbl.push_back(mk("wait_1",      0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0020, W, 1, 0, 0));
    tbl.push_back(mk("wait_2",      0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0020, W, 1, 0, 0));
    tbl.push_back(mk("wait_3",      0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0020, W, 1, 0, 0));
    tbl.push_back(mk("wait_exit",   0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0024, R, 1, 0, 0));
    tbl.push_back(mk("halt",        0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h0000_0024, H, 0, 0, 0));
    tbl.push_back(mk("halted_idle", 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0024, H, 0, 0, 0));
    tbl.push_back(mk("halted_nobr", 0, 1, 32'h80,       0, 32'h0,        0, 0, 1, 32'h0000_0024, H, 0, 0, 0));
    tbl.push_back(mk("resume",      0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h0000_0024, R, 1, 0, 0));
    tbl.push_back(mk("post_resume", 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0028, R, 1, 0, 0));
    tbl.push_back(mk("wait_in",     0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0028, W, 1, 0, 0));
    tbl.push_back(mk("wait_stl_nr", 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0028, W, 1, 0, 0));
    tbl.push_back(mk("wait_stl_rdy",1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0028, R, 1, 0, 0));
    tbl.push_back(mk("jmp_nordy",   0, 0, 32'h0,        1, 32'h300,      0, 0, 0, 32'h0000_0300, R, 1, 1, 0));
    tbl.push_back(mk("wait_again",  0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0000_0300, W, 1, 0, 0));
    tbl.push_back(mk("br_in_wait",  0, 1, 32'h400,      0, 32'h0,        0, 0, 0, 32'h0000_0400, R, 1, 1, 0));
    tbl.push_back(mk("seq_404",     0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0404, R, 1, 0, 0));
    tbl.push_back(mk("br_misalign", 0, 1, 32'h42,       0, 32'h0,        0, 0, 1, 32'h0000_0404, H, 0, 0, 1));
    tbl.push_back(mk("resume_fault",0, 0, 32'h0,        0, 32'h0,        0, 1, 1, 32'h0000_0404, H, 0, 0, 1));
    tbl.push_back(mk("fault_sticky",0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0404, H, 0, 0, 1));

    tbl2.push_back(mk("r2_boot",    0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0000, R, 1, 0, 0));
    tbl2.push_back(mk("r2_seq",     0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0004, R, 1, 0, 0));
    tbl2.push_back(mk("r2_jmp_br",  0, 1, 32'h200,      1, 32'h100,      0, 0, 1, 32'h0000_0100, R, 1, 1, 0));
    tbl2.push_back(mk("r2_stall",   1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 32'h0000_0100, R, 1, 0, 0));
    tbl2.push_back(mk("r2_jmp_odd", 0, 0, 32'h0,        1, 32'h101,      0, 0, 1, 32'h0000_0100, H, 0, 0, 1));

    rst = 1'b1;
    drive_idle();
    #12;
    check("reset_state", 32'h0, B, 1'b0, 1'b0, 1'b0);
`ifdef PC_SEQ_PERF_EN
    check_cnt("reset_fetch_cnt", fetch_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("boot_hold", 32'h0, B, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset in the middle of a cycle, while faulted.
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 32'h0, B, 1'b0, 1'b0, 1'b0);

    drive_idle();
    @(posedge clk);
    #1;
    check("rst_held", 32'h0, B, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (tbl2[i]) apply(tbl2[i]);

`ifdef PC_SEQ_PERF_EN
    check_cnt("fetch_cnt", fetch_cnt, 32'd1);
    check_cnt("redirect_cnt", redirect_cnt, 32'd1);
    check_cnt("stall_cnt", stall_cnt, 32'd1);
`endif

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the architectural program counter and sequences the pcAdder (pc+4) datapath. Each cycle it selects the next fetch address from sequential, branch, jump or reset-vector sources, honouring pipeline stalls and instruction-memory readiness. It sits between the IF stage and the pcAdder/instruction memory. It emits a flush pulse on redirects and a sticky fault on misaligned targets.

Parameters:
XLEN, 32, PC/address width.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
INC, 4, sequential increment, matching the pcAdder constant.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hazard unit holds the PC.
branch_taken  in  1  EX stage resolved a taken branch this cycle.
branch_target  in  XLEN  branch destination.
jump  in  1  jump/JR resolved this cycle.
jump_target  in  XLEN  jump destination.
halt_req  in  1  request to stop fetching.
resume  in  1  leave HALTED; ignored while fault=1.
imem_ready  in  1  instruction memory accepts the current pc.
pc  out  XLEN  current fetch address, registered.
fetch_valid  out  1  pc is a valid fetch request.
flush  out  1  one-cycle pulse to squash the IF/ID instructions.
fault  out  1  sticky misaligned-target error.
state  out  2  FSM state, for debug.

Behaviour:
- Reset (async, any time, including mid-redirect): pc=RESET_VEC, state=BOOT, fetch_valid=0, flush=0, fault=0.
- States are encoded in pkg: BOOT=0, RUN=1, WAIT=2, HALTED=3.
- BOOT: lasts exactly one cycle, then goes to RUN. pc is held and fetch_valid=0.
- RUN: fetch_valid=1. Next-PC priority, evaluated each rising edge: halt_req > jump > branch_taken > stall > !imem_ready > sequential.
  - halt_req: go to HALTED; pc is held.
  - jump or branch_taken:
    - pc <= target and flush=1 for the next cycle only.
    - If the target has bits [1:0]!=0, pc is held, fault is set and the state goes to HALTED.
    - jump beats branch_taken when both are asserted.
    - A redirect is taken even if stall or !imem_ready is asserted (it overrides the stall).
  - stall: pc is held and the state stays RUN.
  - !imem_ready: pc is held and the state goes to WAIT.
  - Otherwise: pc <= pc+INC, truncated to XLEN. 0xFFFF_FFFC wraps to 0x0000_0000 with no fault.
- WAIT: fetch_valid=1 and pc is held.
  - When imem_ready=1: pc <= pc+INC and the state goes to RUN, unless stall is asserted, in which case pc is held and the state goes to RUN.
  - Redirects and halt_req are honoured in WAIT with the same priority as in RUN.
- HALTED: fetch_valid=0 and pc is held.
  - resume=1 with fault=0: go to RUN on the next edge, at the same pc.
  - Redirect inputs are ignored in HALTED.
- Latency: a decision made at edge N is visible on pc after edge N. flush is registered and asserts in the cycle after the redirect edge.
- Only reset clears fault.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- When defined:
  - Adds 32-bit outputs fetch_cnt, redirect_cnt and stall_cnt.
  - fetch_cnt increments on each sequential advance. redirect_cnt increments on each accepted redirect. stall_cnt increments on each RUN cycle held by stall or WAIT.
  - All three saturate at 0xFFFF_FFFF and reset to 0.
- When undefined: the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package pc_seq_pkg holds:
  - the state enum pc_state_t;
  - the localparams INC_DEFAULT and ALIGN_MASK=2'b11;
  - the function is_misaligned().
- One sub-module is natural: the existing pcAdder, instantiated for the pc+INC path. Target selection and the FSM stay in pc_sequencer.

Test Plan:
1. Reset release, imem_ready=1, no events: BOOT for 1 cycle (fetch_valid=0, pc=0). Then pc=0,4,8,0xC on successive cycles.
2. At pc=0x10, pulse branch_taken with branch_target=0x40, stall=1: next cycle pc=0x40 and flush=1 for exactly one cycle. Then pc stays 0x40 while stall=1, and advances to 0x44 after stall drops.
3. Same cycle: jump=1 with jump_target=0x100, branch_taken=1 with branch_target=0x200: pc=0x100 and redirect_cnt (if enabled) increments by 1.
4. branch_target=0x42: pc is held, fault=1, state=HALTED, fetch_valid=0. Then resume=1: the state stays HALTED. Then assert rst mid-cycle: pc=0 and fault=0 immediately.
5. At pc=0xFFFF_FFFC with imem_ready=1: next pc=0x0000_0000 and fault=0.
6. At pc=0x20, hold imem_ready=0 for 3 cycles: state=WAIT and pc=0x20 throughout. Then imem_ready=1: pc=0x24. Then halt_req: HALTED. Then resume: fetch restarts at 0x24.
